// File: rtl/timer_sequencer.sv
// Control FSM for a 4-bit shift/down-counter datapath: detects a serial start pattern,
// shifts in a delay value, paces the countdown with a prescaler and holds done until ack.
module timer_sequencer #(
    parameter int unsigned        PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1101,
    parameter int unsigned        SHIFT_LEN = 4,
    parameter int unsigned        TICK_DIV  = 1000,
    parameter int unsigned        TICK_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data,
    input  logic                 ack,
    input  logic [SHIFT_LEN-1:0] cnt_value,
    output logic                 shift_ena,
    output logic                 count_ena,
    output logic                 counting,
    output logic                 done
);

    localparam int unsigned       SC_W       = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam logic [SC_W-1:0]   SHIFT_LAST = SC_W'(SHIFT_LEN - 1);
    localparam logic [TICK_W-1:0] PRE_LAST   = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StCount, StDone} state_e;

    state_e              state_q;
    logic [PAT_LEN-1:0]  hist_q;
    logic [PAT_LEN-1:0]  hist_next;
    logic [SC_W-1:0]     shift_cnt_q;
    logic [TICK_W-1:0]   pre_q;
    logic                pre_last;

    assign hist_next = {hist_q[PAT_LEN-2:0], data};
    assign pre_last  = (pre_q == PRE_LAST);

    // Suppressed at zero so the datapath counter never wraps to all-ones.
    assign count_ena = (state_q == StCount) && pre_last && (cnt_value != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            shift_cnt_q <= '0;
            pre_q       <= '0;
            shift_ena   <= 1'b0;
            counting    <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    hist_q <= hist_next;
                    if (hist_next == PATTERN) begin
                        state_q     <= StShift;
                        shift_cnt_q <= '0;
                        shift_ena   <= 1'b1;
                    end
                end
                StShift: begin
                    shift_cnt_q <= shift_cnt_q + SC_W'(1);
                    if (shift_cnt_q == SHIFT_LAST) begin
                        state_q   <= StCount;
                        pre_q     <= '0;
                        shift_ena <= 1'b0;
                        counting  <= 1'b1;
                    end
                end
                StCount: begin
                    if (pre_last) begin
                        pre_q <= '0;
                        if (cnt_value == '0) begin
                            state_q  <= StDone;
                            counting <= 1'b0;
                            done     <= 1'b1;
                        end
                    end else begin
                        pre_q <= pre_q + TICK_W'(1);
                    end
                end
                StDone: begin
                    // History is flushed so a fresh, complete pattern is needed to re-arm.
                    if (ack) begin
                        state_q <= StIdle;
                        hist_q  <= '0;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer with a behavioural shift/down-counter datapath
// and a transaction-level model of pattern match, delay and timing.
module tb_timer_sequencer;

    localparam int unsigned TICK = 4;
    localparam logic [3:0]  PAT  = 4'b1101;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       data  = 1'b0;
    logic       ack   = 1'b0;
    logic [3:0] cnt_value;
    logic       shift_ena, count_ena, counting, done;

    logic [3:0] dp = 4'd0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    int   tot_shift = 0, tot_count = 0, tot_pulse = 0, tot_viol = 0;
    int   shift_rise = -1, done_rise = -1;
    logic shift_prev = 1'b0, done_prev = 1'b0;
    bit   stim[$];

    always #5 clk = ~clk;

    timer_sequencer #(
        .PAT_LEN  (4),
        .PATTERN  (PAT),
        .SHIFT_LEN(4),
        .TICK_DIV (TICK),
        .TICK_W   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .ack      (ack),
        .cnt_value(cnt_value),
        .shift_ena(shift_ena),
        .count_ena(count_ena),
        .counting (counting),
        .done     (done)
    );

    // Datapath: MSB-first shift register / down counter, not reset by rst_n.
    assign cnt_value = dp;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (shift_ena) dp <= {dp[2:0], data};
        else if (count_ena) dp <= dp - 4'd1;
    end

    always @(negedge clk) begin
        shift_prev <= shift_ena;
        done_prev  <= done;
        if (shift_ena && !shift_prev) shift_rise <= cyc;
        if (done && !done_prev) done_rise <= cyc;
        tot_shift <= tot_shift + int'(shift_ena);
        tot_count <= tot_count + int'(counting);
        tot_pulse <= tot_pulse + int'(count_ena);
        if ((int'(shift_ena) + int'(counting) + int'(done) > 1) || (shift_ena && count_ena) ||
            (count_ena && cnt_value == 4'd0) || (count_ena && !counting))
            tot_viol <= tot_viol + 1;
    end

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    // Runs the queued stream: model finds the first match, the next 4 bits are the delay.
    task automatic run_txn(input string name, input bit ack_early, input int hold);
        int m, p_m, len;
        int b_shift, b_count, b_pulse, b_viol;
        logic [3:0] h, d;
        bit seen;
        #1;
        h = 4'd0; m = -1; p_m = 0; seen = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            if (m < 0) begin
                h = {h[2:0], stim[i]};
                if (h == PAT) m = i;
            end
        end
        d   = {stim[m+1], stim[m+2], stim[m+3], stim[m+4]};
        len = (int'(d) + 1) * TICK;
        b_shift = tot_shift; b_count = tot_count; b_pulse = tot_pulse; b_viol = tot_viol;
        for (int i = 0; i <= m + 4; i++) begin
            data = stim[i];
            if (ack_early && i > m) ack = 1'b1;
            @(posedge clk); #1;
            if (i == m) p_m = cyc;
        end
        for (int k = 0; k < len + 16 && !seen; k++) begin
            @(negedge clk);
            data = 1'($urandom);
            if (done) seen = 1'b1;
        end
        ack = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: done not seen within %0d cycles", name, len + 16);
        end else begin
            checks++;
            if (cnt_value !== 4'd0) begin
                errors++;
                $display("FAIL %s cnt_at_done: got %0d required 0", name, cnt_value);
            end
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL %s done_hold: cycle %0d done=%b required 1", name, k, done);
                end
            end
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            checks++;
            if ({shift_ena, count_ena, counting, done} !== 4'b0000) begin
                errors++;
                $display("FAIL %s after_ack: outputs %b required 0000", name,
                         {shift_ena, count_ena, counting, done});
            end
        end
        #1;
        checks++;
        if (shift_rise !== p_m) begin
            errors++;
            $display("FAIL %s shift_start: cycle %0d required %0d", name, shift_rise, p_m);
        end
        checks++;
        if (tot_shift - b_shift !== 4) begin
            errors++;
            $display("FAIL %s shift_len: got %0d required 4", name, tot_shift - b_shift);
        end
        checks++;
        if (tot_count - b_count !== len) begin
            errors++;
            $display("FAIL %s count_len: got %0d required %0d", name, tot_count - b_count, len);
        end
        checks++;
        if (tot_pulse - b_pulse !== int'(d)) begin
            errors++;
            $display("FAIL %s pulses: got %0d required %0d", name, tot_pulse - b_pulse, d);
        end
        checks++;
        if (done_rise !== p_m + 4 + len) begin
            errors++;
            $display("FAIL %s done_start: cycle %0d required %0d", name, done_rise, p_m + 4 + len);
        end
        checks++;
        if (tot_viol !== b_viol) begin
            errors++;
            $display("FAIL %s exclusivity: %0d bad cycles required 0", name, tot_viol - b_viol);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({shift_ena, count_ena, counting, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: outputs %b required 0000", {shift_ena, count_ena, counting, done});
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({shift_ena, count_ena, counting, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: outputs %b required 0000",
                     {shift_ena, count_ena, counting, done});
        end
    endtask

    task automatic test_reset_mid_count();
        logic [3:0] saved;
        int b_shift;
        stim.delete();
        push_bits(32'b1101_1010, 8);
        for (int i = 0; i < 8; i++) begin
            data = stim[i];
            @(posedge clk); #1;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (counting !== 1'b1) begin
            errors++;
            $display("FAIL midcount_setup: counting=%b required 1", counting);
        end
        #2;
        saved = cnt_value;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({shift_ena, count_ena, counting, done} !== 4'b0000) begin
            errors++;
            $display("FAIL midcount_async: outputs %b required 0000",
                     {shift_ena, count_ena, counting, done});
        end
        checks++;
        if (cnt_value !== saved) begin
            errors++;
            $display("FAIL midcount_cnt: got %0d required %0d", cnt_value, saved);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        b_shift = tot_shift;
        // Only the tail of the pattern: must not match against pre-reset history.
        for (int i = 0; i < 3; i++) begin
            data = (i == 1) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        checks++;
        if (tot_shift - b_shift !== 0) begin
            errors++;
            $display("FAIL post_reset_partial: shift cycles %0d required 0", tot_shift - b_shift);
        end
        stim.delete();
        push_bits(32'b1101_0011, 8);
        run_txn("post_reset", 1'b0, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            stim.delete();
            push_bits($urandom, $urandom_range(0, 8));
            push_bits(32'(PAT), 4);
            push_bits($urandom, 4);
            run_txn("random", 1'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        // delay 2
        stim.delete(); push_bits(32'b1101_0010, 8);
        run_txn("delay2", 1'b0, 1);
        // delay 0
        stim.delete(); push_bits(32'b1101_0000, 8);
        run_txn("delay0", 1'b0, 0);
        // overlapping pattern inside the delay bits
        stim.delete(); push_bits(32'b0110_1101_0, 9);
        run_txn("overlap", 1'b0, 0);
        // ack held through shift/count, then 5 idle done cycles
        stim.delete(); push_bits(32'b1101_0101, 8);
        run_txn("ack_early", 1'b1, 5);
        // delay 15, with a prefix that would match against stale history
        stim.delete(); push_bits(32'b101_1101_1111, 11);
        run_txn("delay15", 1'b0, 2);
        test_reset_mid_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
